// File: rtl/c2hdl_bus_pkg.sv
// Shared bus definitions for the C-to-HDL core memory arbiter and later core schedulers.
package c2hdl_bus_pkg;

  localparam logic [2:0] SIZE_B = 3'd0;
  localparam logic [2:0] SIZE_H = 3'd1;
  localparam logic [2:0] SIZE_W = 3'd2;

  localparam int BUS_AW = 32;
  localparam int BUS_DW = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  typedef struct packed {
    logic [BUS_AW-1:0] addr;
    logic [2:0]        size;
    logic              write;
    logic [BUS_DW-1:0] wdata;
  } req_t;

endpackage

// File: rtl/c2hdl_mem_arbiter_if.sv
// Requester and memory bus bundle of the arbiter; master is the arbiter side, slave the environment.
interface c2hdl_mem_arbiter_if #(
  parameter int N  = 2,
  parameter int AW = 32,
  parameter int DW = 32
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_write;
  logic [3*N-1:0]  req_size;
  logic [AW*N-1:0] req_addr;
  logic [DW*N-1:0] req_wdata;
  logic [N-1:0]    req_ready;
  logic [DW-1:0]   req_rdata;

  logic            mem_valid;
  logic            mem_write;
  logic [2:0]      mem_size;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;
  logic            mem_ready;

  logic [IW-1:0]   grant_id;
  logic            busy;
  logic            err;
  logic            err_sticky;

  modport master (
    input  req_valid, req_write, req_size, req_addr, req_wdata, mem_rdata, mem_ready,
    output req_ready, req_rdata, mem_valid, mem_write, mem_size, mem_addr, mem_wdata,
           grant_id, busy, err, err_sticky
  );

  modport slave (
    output req_valid, req_write, req_size, req_addr, req_wdata, mem_rdata, mem_ready,
    input  req_ready, req_rdata, mem_valid, mem_write, mem_size, mem_addr, mem_wdata,
           grant_id, busy, err, err_sticky
  );

endinterface

// File: rtl/c2hdl_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first pending bit at or after i_ptr, wrapping mod N.
module c2hdl_mem_arbiter_rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  i_pend,
  input  logic [IW-1:0] i_ptr,
  output logic          o_found,
  output logic [IW-1:0] o_idx
);

  // Each candidate's distance from the pointer; the closest pending one wins.
  always_comb begin
    int w_best;
    int w_dist;
    w_best  = N;
    w_dist  = 0;
    o_idx   = '0;
    for (int j = 0; j < N; j++) begin
      w_dist = (j - int'(i_ptr) + N) % N;
      if (i_pend[j] && (w_dist < w_best)) begin
        w_best = w_dist;
        o_idx  = IW'(j);
      end
    end
    o_found = (w_best < N);
  end

endmodule

// File: rtl/c2hdl_mem_arbiter.sv
// Round-robin arbiter sharing one memory port among N generated cores:
// pulsed requests are captured, one transaction is outstanding, a watchdog aborts silent memory.
module c2hdl_mem_arbiter
  import c2hdl_bus_pkg::*;
#(
  parameter int N      = 2,
  parameter int AW     = BUS_AW,
  parameter int DW     = BUS_DW,
  parameter int TO_CYC = 255
) (
  input logic                 clk,
  input logic                 rstb,
  c2hdl_mem_arbiter_if.master bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  state_t        r_state;
  logic [N-1:0]  r_pend;
  logic [N-1:0]  r_ready;
  logic [N-1:0]  w_cap;
  logic [IW-1:0] r_rr;
  logic [IW-1:0] r_grant;
  logic [IW-1:0] w_idx;
  logic          w_found;
  logic [15:0]   r_wd;
  req_t          r_req [N];
  logic          r_mvalid;
  logic          r_mwrite;
  logic [2:0]    r_msize;
  logic [AW-1:0] r_maddr;
  logic [DW-1:0] r_mwdata;
  logic [DW-1:0] r_rdata;
  logic          r_err;
  logic          r_sticky;

  // A core already pending, or being acknowledged this cycle, cannot re-arm.
  assign w_cap = bus.req_valid & ~r_pend & ~r_ready;

  c2hdl_mem_arbiter_rr_pick #(.N(N), .IW(IW)) u_pick (
    .i_pend (r_pend),
    .i_ptr  (r_rr),
    .o_found(w_found),
    .o_idx  (w_idx)
  );

  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (w_cap[i]) begin
        r_req[i].addr  <= BUS_AW'(bus.req_addr[i*AW +: AW]);
        r_req[i].size  <= bus.req_size[i*3 +: 3];
        r_req[i].write <= bus.req_write[i];
        r_req[i].wdata <= BUS_DW'(bus.req_wdata[i*DW +: DW]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_state  <= IDLE;
      r_pend   <= '0;
      r_rr     <= '0;
      r_grant  <= '0;
      r_wd     <= '0;
      r_ready  <= '0;
      r_rdata  <= '0;
      r_mvalid <= 1'b0;
      r_mwrite <= 1'b0;
      r_msize  <= '0;
      r_maddr  <= '0;
      r_mwdata <= '0;
      r_err    <= 1'b0;
      r_sticky <= 1'b0;
    end else begin
      r_ready <= '0;
      r_err   <= 1'b0;
      r_pend  <= r_pend | w_cap;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_mvalid <= 1'b1;
            r_mwrite <= r_req[w_idx].write;
            r_msize  <= r_req[w_idx].size;
            r_maddr  <= AW'(r_req[w_idx].addr);
            r_mwdata <= DW'(r_req[w_idx].wdata);
            r_grant  <= w_idx;
            r_wd     <= '0;
            r_state  <= ISSUE;
          end
        end
        ISSUE: begin
          r_wd <= r_wd + 16'd1;
          // A completion on the final watchdog cycle still counts as a normal response.
          if (bus.mem_ready) begin
            r_rdata          <= bus.mem_rdata;
            r_mvalid         <= 1'b0;
            r_ready[r_grant] <= 1'b1;
            r_state          <= RESP;
          end else if (r_wd == 16'(TO_CYC - 1)) begin
            r_rdata          <= '0;
            r_mvalid         <= 1'b0;
            r_err            <= 1'b1;
            r_sticky         <= 1'b1;
            r_ready[r_grant] <= 1'b1;
            r_state          <= RESP;
          end
        end
        RESP: begin
          r_pend[r_grant] <= 1'b0;
          r_rr            <= (r_grant == IW'(N - 1)) ? '0 : r_grant + 1'b1;
          r_state         <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = r_ready;
  assign bus.req_rdata  = r_rdata;
  assign bus.mem_valid  = r_mvalid;
  assign bus.mem_write  = r_mwrite;
  assign bus.mem_size   = r_msize;
  assign bus.mem_addr   = r_maddr;
  assign bus.mem_wdata  = r_mwdata;
  assign bus.grant_id   = r_grant;
  assign bus.busy       = (r_state != IDLE);
  assign bus.err        = r_err;
  assign bus.err_sticky = r_sticky;

endmodule

// File: tb/tb_c2hdl_mem_arbiter.sv
// Bench for c2hdl_mem_arbiter: vector table plus hand-written sequences, scoreboard-checked.
module tb_c2hdl_mem_arbiter;
  import c2hdl_bus_pkg::*;

  localparam int N      = 2;
  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int TO_CYC = 8;

  logic clk  = 1'b0;
  logic rstb = 1'b0;
  always #5 clk = ~clk;

  c2hdl_mem_arbiter_if #(.N(N), .AW(AW), .DW(DW)) bus ();

  c2hdl_mem_arbiter #(.N(N), .AW(AW), .DW(DW), .TO_CYC(TO_CYC)) dut (
    .clk (clk),
    .rstb(rstb),
    .bus (bus)
  );

  typedef struct {
    logic [1:0]  mask;
    logic [1:0]  wr;
    logic [2:0]  sz0;
    logic [2:0]  sz1;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] d0;
    logic [31:0] d1;
    int          dly;
    int          exp_first;
    int          exp_lat;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  sz;
    logic [31:0] wdata;
    int          id;
    int          dur;
  } mexp_t;

  typedef struct {
    int          id;
    logic [31:0] rdata;
    logic        err;
  } rexp_t;

  mexp_t exp_mem[$];
  rexp_t exp_rsp[$];
  int    checks     = 0;
  int    errors     = 0;
  int    mem_delay  = 0;
  logic  exp_sticky = 1'b0;

  function automatic logic [31:0] mfn(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEAD_BEEF : {a[15:0], ~a[15:0]};
  endfunction

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_txn(input vec_t v, input int c);
    mexp_t m;
    rexp_t r;
    m.addr  = (c != 0) ? v.a1 : v.a0;
    m.wr    = v.wr[c];
    m.sz    = (c != 0) ? v.sz1 : v.sz0;
    m.wdata = (c != 0) ? v.d1 : v.d0;
    m.id    = c;
    m.dur   = v.exp_err ? TO_CYC : v.dly + 1;
    r.id    = c;
    r.rdata = v.exp_err ? 32'h0 : mfn(m.addr);
    r.err   = v.exp_err;
    exp_mem.push_back(m);
    exp_rsp.push_back(r);
  endtask

  task automatic drive(input vec_t v);
    bus.req_valid = v.mask;
    bus.req_write = v.wr;
    bus.req_size  = {v.sz1, v.sz0};
    bus.req_addr  = {v.a1, v.a0};
    bus.req_wdata = {v.d1, v.d0};
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((exp_mem.size() != 0 || exp_rsp.size() != 0 || bus.busy) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL idle_timeout: still busy after %0d cycles, required idle", n);
    end
  endtask

  task automatic run_vector(input vec_t v);
    int n;
    mem_delay = v.dly;
    if (v.mask[v.exp_first]) push_txn(v, v.exp_first);
    if (v.mask[1 - v.exp_first]) push_txn(v, 1 - v.exp_first);
    drive(v);
    tick();
    bus.req_valid = '0;
    n = 1;
    while (bus.req_ready == '0 && n < 60) begin
      tick();
      n++;
    end
    chk("latency", 32'(n), 32'(v.exp_lat));
    wait_idle(60);
  endtask

  task automatic check_reset_state();
    chk("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_err_sticky", 32'(bus.err_sticky), 32'd0);
    chk("rst_grant", 32'(bus.grant_id), 32'd0);
    chk("rst_req_rdata", bus.req_rdata, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
  endtask

  // Memory: completes after mem_delay cycles of mem_valid, or never when mem_delay < 0.
  initial begin : mem_model
    int cnt = 0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.mem_valid === 1'b1) begin
        bus.mem_ready = (mem_delay >= 0 && cnt == mem_delay);
        bus.mem_rdata = bus.mem_ready ? mfn(bus.mem_addr) : (32'hBAAD_0000 | 32'(cnt));
        cnt++;
      end else begin
        bus.mem_ready = 1'b0;
        cnt = 0;
      end
    end
  end

  initial begin : monitor
    logic  prev_mv;
    logic  prev_rdy;
    logic  have;
    int    dur;
    mexp_t cur;
    rexp_t r;
    prev_mv = 1'b0; prev_rdy = 1'b0; have = 1'b0; dur = 0;
    forever begin
      @(posedge clk);
      #2;
      if (!rstb) begin
        prev_mv = 1'b0; prev_rdy = 1'b0; have = 1'b0;
      end else begin
        if (bus.mem_valid === 1'b1) begin
          if (!prev_mv) begin
            dur = 1;
            if (exp_mem.size() == 0) begin
              checks++; errors++; have = 1'b0;
              $display("FAIL unexpected_issue: grant=%0d addr=%0h, required no issue", bus.grant_id, bus.mem_addr);
            end else begin
              cur  = exp_mem.pop_front();
              have = 1'b1;
              chk("issue_grant", 32'(bus.grant_id), 32'(cur.id));
              chk("issue_addr", bus.mem_addr, cur.addr);
              chk("issue_write", 32'(bus.mem_write), 32'(cur.wr));
              chk("issue_size", 32'(bus.mem_size), 32'(cur.sz));
              chk("issue_wdata", bus.mem_wdata, cur.wdata);
              chk("issue_busy", 32'(bus.busy), 32'd1);
            end
          end else begin
            dur++;
            if (have) begin
              chk("hold_addr", bus.mem_addr, cur.addr);
              chk("hold_wdata", bus.mem_wdata, cur.wdata);
              chk("hold_size", 32'(bus.mem_size), 32'(cur.sz));
            end
          end
        end else if (prev_mv && have) begin
          if (cur.dur >= 0) chk("valid_cycles", 32'(dur), 32'(cur.dur));
          have = 1'b0;
        end
        if (prev_rdy) chk("ready_pulse_width", 32'(bus.req_ready), 32'd0);
        if (bus.req_ready != '0) begin
          if (exp_rsp.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_ready: req_ready=%b, required none", bus.req_ready);
          end else begin
            r = exp_rsp.pop_front();
            exp_sticky = exp_sticky | r.err;
            chk("ready_core", 32'(bus.req_ready), 32'(1) << r.id);
            chk("resp_grant", 32'(bus.grant_id), 32'(r.id));
            chk("resp_rdata", bus.req_rdata, r.rdata);
            chk("resp_err", 32'(bus.err), 32'(r.err));
            chk("resp_err_sticky", 32'(bus.err_sticky), 32'(exp_sticky));
          end
        end
        prev_mv  = (bus.mem_valid === 1'b1);
        prev_rdy = |bus.req_ready;
      end
    end
  end

  initial begin : watchdog
    #50000;
    $display("FAIL global_timeout: simulation did not reach its end");
    $fatal(1, "global timeout");
  end

  initial begin : main
    vec_t vt[8];
    vec_t v;
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_size  = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    rstb = 1'b0;
    tick();
    tick();
    check_reset_state();
    rstb = 1'b1;

    //          mask   wr     sz0     sz1     a0            a1            d0            d1            dly first lat err
    vt[0] = '{2'b11, 2'b01, SIZE_W, SIZE_W, 32'h0000_0010, 32'h0000_0020, 32'h1111_2222, 32'h0000_0000, 0, 0, 3, 1'b0};
    vt[1] = '{2'b01, 2'b00, SIZE_W, SIZE_W, 32'h0000_0100, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0, 0, 3, 1'b0};
    vt[2] = '{2'b11, 2'b10, SIZE_H, SIZE_B, 32'h0000_0204, 32'h0000_0302, 32'h0000_0000, 32'h0000_CAFE, 1, 1, 4, 1'b0};
    vt[3] = '{2'b10, 2'b00, SIZE_W, 3'd7,   32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000, 0, 1, 3, 1'b0};
    vt[4] = '{2'b01, 2'b01, SIZE_W, SIZE_W, 32'h0000_0400, 32'h0000_0000, 32'h0BAD_F00D, 32'h0000_0000, 5, 0, 8, 1'b0};
    vt[5] = '{2'b11, 2'b00, SIZE_W, SIZE_W, 32'h0000_0480, 32'h0000_0484, 32'h0000_0000, 32'h0000_0000, 7, 1, 10, 1'b0};
    vt[6] = '{2'b01, 2'b00, SIZE_W, SIZE_W, 32'h0000_04C0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, -1, 0, 10, 1'b1};
    vt[7] = '{2'b10, 2'b00, SIZE_W, SIZE_W, 32'h0000_0000, 32'h0000_0500, 32'h0000_0000, 32'h0000_0000, 0, 1, 3, 1'b0};

    for (int i = 0; i < 8; i++) run_vector(vt[i]);

    // Re-pulsing while pending, the last pulse landing on the core's own req_ready.
    mem_delay = 3;
    v = '{2'b01, 2'b00, SIZE_W, SIZE_W, 32'h0000_0600, 32'h0, 32'h0, 32'h0, 3, 0, 6, 1'b0};
    push_txn(v, 0);
    drive(v);
    for (int k = 0; k < 4; k++) begin
      bus.req_valid = 2'b01;
      tick();
      bus.req_valid = 2'b00;
      tick();
    end
    wait_idle(30);
    repeat (6) tick();
    chk("repulse_busy", 32'(bus.busy), 32'd0);
    chk("repulse_single_issue", 32'(exp_mem.size()), 32'd0);

    // Reset in the middle of a silent transaction, with another core pending.
    mem_delay = -1;
    begin
      mexp_t m;
      m.addr = 32'h0000_0700; m.wr = 1'b0; m.sz = SIZE_W; m.wdata = 32'h0; m.id = 1; m.dur = -1;
      exp_mem.push_back(m);
    end
    bus.req_addr  = {32'h0000_0700, 32'h0000_0800};
    bus.req_write = 2'b00;
    bus.req_size  = {SIZE_W, SIZE_W};
    bus.req_valid = 2'b10;
    tick();
    bus.req_valid = 2'b00;
    tick();
    bus.req_valid = 2'b01;
    tick();
    bus.req_valid = 2'b00;
    tick();
    tick();
    rstb = 1'b0;
    tick();
    rstb = 1'b1;
    exp_sticky = 1'b0;
    check_reset_state();
    mem_delay = 0;
    repeat (8) tick();
    chk("post_reset_idle", 32'(bus.busy), 32'd0);
    chk("post_reset_no_issue", 32'(bus.mem_valid), 32'd0);

    v = '{2'b11, 2'b00, SIZE_W, SIZE_W, 32'h0000_0900, 32'h0000_0904, 32'h0, 32'h0, 0, 0, 3, 1'b0};
    run_vector(v);

    repeat (4) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
